// File: rtl/operand_loader.sv
// operand_loader: debounced sequential entry of X, Y and carry-in for the adder lab datapath.
module operand_loader #(
    parameter int WIDTH = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             Reset,
    input  logic             KEY,
    input  logic [WIDTH:0]   SW,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic             Cin,
    output logic             Valid,
    output logic [1:0]       Phase
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {LOAD_X = 2'd0, LOAD_Y = 2'd1, SHOW = 2'd2} state_t;
    logic key_s1, key_s2, db, press, settle;
    logic [CW-1:0] cnt;
    state_t state, next;
    assign settle = (key_s2 != db) && (cnt == LAST);
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            db     <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            cnt    <= (key_s2 == db || settle) ? '0 : cnt + CW'(1);
            db     <= settle ? key_s2 : db;
            // only the released-to-pressed transition of the debounced level is an event
            press  <= settle && db;
        end
    end
    always_comb begin
        next = state;
        case (state)
            LOAD_X:  next = press ? LOAD_Y : LOAD_X;
            LOAD_Y:  next = press ? SHOW : LOAD_Y;
            SHOW:    next = press ? LOAD_X : SHOW;
            default: next = LOAD_X;
        endcase
    end
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state <= LOAD_X;
            X     <= '0;
            Y     <= '0;
            Cin   <= 1'b0;
            Valid <= 1'b0;
        end else begin
            state <= next;
            if (press && state == LOAD_X) X <= SW[WIDTH-1:0];
            if (press && state == LOAD_Y) begin
                Y     <= SW[WIDTH-1:0];
                Cin   <= SW[WIDTH];
                Valid <= 1'b1;
            end
            if (press && state == SHOW) Valid <= 1'b0;
        end
    end
    assign Phase = state;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed scenario tasks for operand_loader with DEBOUNCE_CYCLES=4.
module tb_operand_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b1;
    logic [4:0] sw  = '0;
    logic [3:0] x, y;
    logic       cin, valid;
    logic [1:0] phase;
    int errors = 0;
    int checks = 0;

    operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50(clk), .Reset(rst), .KEY(key), .SW(sw),
        .X(x), .Y(y), .Cin(cin), .Valid(valid), .Phase(phase)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; key = 1'b1; sw = '0;
        cyc(1);
        checks++; if (x !== 4'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", x); end
        checks++; if (y !== 4'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", y); end
        checks++; if (cin !== 1'b0) begin errors++; $display("FAIL reset_cin got=%b exp=0", cin); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        cyc(2);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_load_x;
        sw = 5'b0_0101; key = 1'b0;
        cyc(6);
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL loadx_early_phase got=%0d exp=0", phase); end
        cyc(1);
        checks++; if (x !== 4'd5) begin errors++; $display("FAIL loadx_x got=%0d exp=5", x); end
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL loadx_phase got=%0d exp=1", phase); end
        cyc(3);
        key = 1'b1;
        cyc(10);
    endtask

    task automatic test_load_y;
        sw = 5'b1_0011; key = 1'b0;
        cyc(7);
        checks++; if (y !== 4'd3) begin errors++; $display("FAIL loady_y got=%0d exp=3", y); end
        checks++; if (cin !== 1'b1) begin errors++; $display("FAIL loady_cin got=%b exp=1", cin); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL loady_valid got=%b exp=1", valid); end
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL loady_phase got=%0d exp=2", phase); end
        checks++; if (x + y + cin !== 9) begin errors++; $display("FAIL loady_sum got=%0d exp=9", x + y + cin); end
        cyc(3);
        key = 1'b1;
        cyc(10);
    endtask

    task automatic test_glitch_and_show;
        sw = 5'b1_1111;
        for (int i = 0; i < 5; i++) begin
            key = 1'b0; cyc(3);
            key = 1'b1; cyc(3);
        end
        cyc(6);
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL glitch_phase got=%0d exp=2", phase); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL glitch_valid got=%b exp=1", valid); end
        checks++; if (x !== 4'd5 || y !== 4'd3) begin errors++; $display("FAIL glitch_xy got=%0d,%0d exp=5,3", x, y); end
        key = 1'b0; cyc(4);
        key = 1'b1; cyc(10);
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL show_phase got=%0d exp=0", phase); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL show_valid got=%b exp=0", valid); end
        checks++; if (x !== 4'd5 || y !== 4'd3 || cin !== 1'b1) begin errors++; $display("FAIL show_retain got=%0d,%0d,%b exp=5,3,1", x, y, cin); end
    endtask

    task automatic test_long_hold;
        sw = 5'b0_0111; key = 1'b0;
        cyc(100);
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL hold_phase got=%0d exp=1", phase); end
        checks++; if (x !== 4'd7) begin errors++; $display("FAIL hold_x got=%0d exp=7", x); end
        key = 1'b1;
        cyc(10);
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL hold_release_phase got=%0d exp=1", phase); end
    endtask

    task automatic test_mid_reset;
        sw = 5'b1_1001; key = 1'b0;
        cyc(2);
        key = 1'b1; rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        checks++; if (x !== 4'd0) begin errors++; $display("FAIL midrst_x got=%0d exp=0", x); end
        checks++; if (y !== 4'd0) begin errors++; $display("FAIL midrst_y got=%0d exp=0", y); end
        checks++; if (cin !== 1'b0) begin errors++; $display("FAIL midrst_cin got=%b exp=0", cin); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", valid); end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL midrst_phase got=%0d exp=0", phase); end
        cyc(20);
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL midrst_nopress_phase got=%0d exp=0", phase); end
        checks++; if (x !== 4'd0) begin errors++; $display("FAIL midrst_nopress_x got=%0d exp=0", x); end
    endtask

    task automatic test_held_through_reset;
        sw = 5'b0_1010; key = 1'b0; rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(5);
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL heldrst_early_phase got=%0d exp=0", phase); end
        cyc(2);
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL heldrst_phase got=%0d exp=1", phase); end
        checks++; if (x !== 4'd10) begin errors++; $display("FAIL heldrst_x got=%0d exp=10", x); end
        key = 1'b1;
        cyc(10);
    endtask

    initial begin
        test_reset;
        test_load_x;
        test_load_y;
        test_glitch_and_show;
        test_long_hold;
        test_mid_reset;
        test_held_through_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
